// File: rtl/microcode_sequencer_if.sv
// Bundle between instruction latch, external microcode ROM, datapath and the sequencer.
// The sequencer takes the slave side; fetch/ROM/datapath take the master side.
interface microcode_sequencer_if #(
  parameter int NREG  = 4,
  parameter int PW    = 16,
  parameter int OP_W  = 4,
  parameter int STEPS = 8
) ();
  localparam int RW = $clog2(NREG);
  localparam int SW = $clog2(STEPS);

  logic                 instr_valid;
  logic                 instr_ready;
  logic [OP_W-1:0]      opcode;
  logic [RW-1:0]        rs;
  logic [RW-1:0]        rd;
  logic                 stall;
  logic [OP_W+SW-1:0]   ucode_addr;
  logic [PW+2:0]        ucode_data;
  logic [PW-1:0]        ctrl_out;
  logic [NREG-1:0]      reg_in_en;
  logic [NREG-1:0]      reg_out_en;
  logic                 ctrl_valid;
  logic                 done;
  logic                 decode_err;

  modport master (
    output instr_valid, opcode, rs, rd, stall, ucode_data,
    input  instr_ready, ucode_addr, ctrl_out, reg_in_en, reg_out_en,
           ctrl_valid, done, decode_err
  );

  modport slave (
    input  instr_valid, opcode, rs, rd, stall, ucode_data,
    output instr_ready, ucode_addr, ctrl_out, reg_in_en, reg_out_en,
           ctrl_valid, done, decode_err
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Steps through per-opcode microcode from an asynchronous external ROM and expands each
// microword into registered plain control bits plus one-hot register-file enables.
module microcode_sequencer #(
  parameter int NREG  = 4,
  parameter int PW    = 16,
  parameter int OP_W  = 4,
  parameter int STEPS = 8
) (
  input logic                   clk,
  input logic                   reset,
  microcode_sequencer_if.slave  bus
);
  localparam int RW = $clog2(NREG);
  localparam int SW = $clog2(STEPS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            r_state;
  logic [SW-1:0]     r_step;
  logic [OP_W-1:0]   r_opcode;
  logic [RW-1:0]     r_rs;
  logic [RW-1:0]     r_rd;
  logic              r_ready;
  logic [PW-1:0]     r_ctrl;
  logic [NREG-1:0]   r_in_en;
  logic [NREG-1:0]   r_out_en;
  logic              r_valid;
  logic              r_done;
  logic              r_err;

  logic              w_end;
  logic              w_rin;
  logic              w_rout;
  logic              w_last;
  logic [PW-1:0]     w_plain;
  logic [NREG-1:0]   w_rd_oh;
  logic [NREG-1:0]   w_rs_oh;

  assign w_end   = bus.ucode_data[0];
  assign w_rin   = bus.ucode_data[1];
  assign w_rout  = bus.ucode_data[2];
  assign w_plain = bus.ucode_data[PW+2:3];
  assign w_last  = w_end | (r_step == SW'(STEPS-1));

  // An index with no matching register decodes to all zeros, which doubles as the error flag.
  always_comb begin
    w_rd_oh = '0;
    w_rs_oh = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      w_rd_oh[i] = (r_rd == RW'(i));
      w_rs_oh[i] = (r_rs == RW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_step   <= '0;
      r_opcode <= '0;
      r_rs     <= '0;
      r_rd     <= '0;
      r_ready  <= 1'b1;
      r_ctrl   <= '0;
      r_in_en  <= '0;
      r_out_en <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ctrl   <= '0;
      r_in_en  <= '0;
      r_out_en <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.instr_valid) begin
            r_opcode <= bus.opcode;
            r_rs     <= bus.rs;
            r_rd     <= bus.rd;
            r_step   <= '0;
            r_ready  <= 1'b0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          if (!bus.stall) begin
            r_ctrl   <= w_plain;
            r_valid  <= 1'b1;
            r_in_en  <= w_rin  ? w_rd_oh : '0;
            r_out_en <= w_rout ? w_rs_oh : '0;
            r_err    <= (w_rin & ~|w_rd_oh) | (w_rout & ~|w_rs_oh);
            if (w_last) begin
              r_done  <= 1'b1;
              r_step  <= '0;
              r_ready <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_step <= r_step + SW'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.instr_ready = r_ready;
  assign bus.ucode_addr  = {r_opcode, r_step};
  assign bus.ctrl_out    = r_ctrl;
  assign bus.reg_in_en   = r_in_en;
  assign bus.reg_out_en  = r_out_en;
  assign bus.ctrl_valid  = r_valid;
  assign bus.done        = r_done;
  assign bus.decode_err  = r_err;
endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a transaction-level model of the sequencing rules.
module tb_microcode_sequencer;
  localparam int NREG  = 4;
  localparam int PW    = 16;
  localparam int OP_W  = 4;
  localparam int STEPS = 8;
  localparam int AW    = OP_W + $clog2(STEPS);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  microcode_sequencer_if #(.NREG(NREG), .PW(PW), .OP_W(OP_W), .STEPS(STEPS)) bus ();
  microcode_sequencer #(.NREG(NREG), .PW(PW), .OP_W(OP_W), .STEPS(STEPS)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  microcode_sequencer_if #(.NREG(3), .PW(PW), .OP_W(OP_W), .STEPS(STEPS)) bus3 ();
  microcode_sequencer #(.NREG(3), .PW(PW), .OP_W(OP_W), .STEPS(STEPS)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  logic [PW+2:0] rom [0:(1<<AW)-1];
  logic [PW+2:0] rom3_word;
  assign bus.ucode_data  = rom[bus.ucode_addr];
  assign bus3.ucode_data = rom3_word;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one instruction in flight, its current microstep, and what the
  // registered outputs must show on the next cycle.
  logic            m_on = 1'b0;
  logic            m_busy;
  logic [OP_W-1:0] m_op;
  logic [1:0]      m_rs, m_rd;
  int              m_step;
  logic [PW+2:0]   m_w;
  logic [PW-1:0]   e_ctrl;
  logic [NREG-1:0] e_in, e_out;
  logic            e_valid, e_done, e_err;

  function automatic logic [AW-1:0] m_addr();
    return AW'(int'(m_op) * STEPS + m_step);
  endfunction

  always @(negedge clk) begin
    if (m_on) begin
      check("ctrl_out",    64'(bus.ctrl_out),    64'(e_ctrl));
      check("reg_in_en",   64'(bus.reg_in_en),   64'(e_in));
      check("reg_out_en",  64'(bus.reg_out_en),  64'(e_out));
      check("ctrl_valid",  64'(bus.ctrl_valid),  64'(e_valid));
      check("done",        64'(bus.done),        64'(e_done));
      check("decode_err",  64'(bus.decode_err),  64'(e_err));
      check("instr_ready", 64'(bus.instr_ready), 64'(!m_busy));
      if (m_busy) check("ucode_addr", 64'(bus.ucode_addr), 64'(m_addr()));
    end
    e_ctrl = '0; e_in = '0; e_out = '0; e_valid = 1'b0; e_done = 1'b0; e_err = 1'b0;
    if (reset) begin
      m_on = 1'b1; m_busy = 1'b0; m_op = '0; m_rs = '0; m_rd = '0; m_step = 0;
    end else if (!m_busy) begin
      if (bus.instr_valid) begin
        m_op = bus.opcode; m_rs = bus.rs; m_rd = bus.rd; m_step = 0; m_busy = 1'b1;
      end
    end else if (!bus.stall) begin
      m_w     = rom[m_addr()];
      e_ctrl  = m_w[PW+2:3];
      e_valid = 1'b1;
      e_in    = m_w[1] ? (NREG'(1) << m_rd) : '0;
      e_out   = m_w[2] ? (NREG'(1) << m_rs) : '0;
      if (m_w[0] || m_step == STEPS - 1) begin
        e_done = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_step++;
      end
    end
  end

  task automatic go();
    @(posedge clk); #1;
  endtask

  int nv, nd, n19, dpos;

  initial begin
    bus.instr_valid = 1'b0; bus.opcode = '0; bus.rs = '0; bus.rd = '0; bus.stall = 1'b0;
    bus3.instr_valid = 1'b0; bus3.opcode = '0; bus3.rs = '0; bus3.rd = '0; bus3.stall = 1'b0;
    rom3_word = '0;
    for (int a = 0; a < (1 << AW); a++) rom[AW'(a)] = '0;
    rom[AW'('h18)] = {16'hA5A5, 3'b100};
    rom[AW'('h19)] = {16'hA5A5, 3'b010};
    rom[AW'('h1A)] = {16'hA5A5, 3'b011};
    for (int s = 0; s < STEPS; s++) rom[AW'(40 + s)] = {16'hC000 | 16'(s), 3'b110};
    for (int s = 0; s < 5; s++) rom[AW'(48 + s)] = {16'h6000 | 16'(s), (s == 4) ? 3'b111 : 3'b110};

    // 1: reset then idle
    go(); go(); go(); reset = 1'b0;
    @(negedge clk);
    check("t1 ready",  64'(bus.instr_ready), 64'd1);
    check("t1 valid",  64'(bus.ctrl_valid),  64'd0);
    check("t1 ctrl",   64'(bus.ctrl_out),    64'd0);
    check("t1 in_en",  64'(bus.reg_in_en),   64'd0);
    check("t1 done",   64'(bus.done),        64'd0);
    check("t1 ready3", 64'(bus3.instr_ready), 64'd1);

    // 2: three-step instruction, literal per-cycle expectations
    go(); bus.instr_valid = 1'b1; bus.opcode = 4'd3; bus.rs = 2'd1; bus.rd = 2'd2;
    go(); bus.instr_valid = 1'b0;
    @(negedge clk);
    check("t2 addr0",  64'(bus.ucode_addr),  64'h18);
    check("t2 busy",   64'(bus.instr_ready), 64'd0);
    #1 check("t2 model out_en", 64'(e_out), 64'h2);
    @(negedge clk);
    check("t2 addr1",  64'(bus.ucode_addr),  64'h19);
    check("t2 out0",   64'(bus.reg_out_en),  64'b0010);
    check("t2 in0",    64'(bus.reg_in_en),   64'b0000);
    check("t2 ctrl0",  64'(bus.ctrl_out),    64'hA5A5);
    check("t2 valid0", 64'(bus.ctrl_valid),  64'd1);
    check("t2 done0",  64'(bus.done),        64'd0);
    @(negedge clk);
    check("t2 addr2",  64'(bus.ucode_addr),  64'h1A);
    check("t2 in1",    64'(bus.reg_in_en),   64'b0100);
    check("t2 out1",   64'(bus.reg_out_en),  64'b0000);
    check("t2 done1",  64'(bus.done),        64'd0);
    #1 check("t2 model done", 64'(e_done), 64'd1);
    @(negedge clk);
    check("t2 in2",    64'(bus.reg_in_en),   64'b0100);
    check("t2 done2",  64'(bus.done),        64'd1);
    check("t2 ready",  64'(bus.instr_ready), 64'd1);
    @(negedge clk);
    check("t2 quiet",  64'(bus.ctrl_valid),  64'd0);

    // 3: same instruction with a two-cycle stall at step 1
    go(); bus.instr_valid = 1'b1;
    go(); bus.instr_valid = 1'b0;
    n19 = 0; nv = 0; nd = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (bus.ucode_addr == AW'('h19) && !bus.instr_ready) n19++;
      if (bus.ctrl_valid) nv++;
      if (bus.done) nd++;
      go(); bus.stall = (k == 1 || k == 2);
    end
    bus.stall = 1'b0;
    check("t3 addr held",  64'(n19), 64'd3);
    check("t3 live words", 64'(nv),  64'd3);
    check("t3 done count", 64'(nd),  64'd1);

    // 4: no end bit anywhere -> forced termination at the last step
    go(); bus.instr_valid = 1'b1; bus.opcode = 4'd5; bus.rs = 2'd0; bus.rd = 2'd1;
    go(); bus.instr_valid = 1'b0;
    nv = 0; nd = 0; dpos = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus.ctrl_valid) nv++;
      if (bus.done) begin nd++; dpos = nv; end
      go();
    end
    check("t4 live words", 64'(nv),   64'd8);
    check("t4 done count", 64'(nd),   64'd1);
    check("t4 done pos",   64'(dpos), 64'd8);
    check("t4 ready",      64'(bus.instr_ready), 64'd1);

    // 6: reset during step 2 of a five-step instruction
    bus.instr_valid = 1'b1; bus.opcode = 4'd6; bus.rs = 2'd3; bus.rd = 2'd0;
    go(); bus.instr_valid = 1'b0;
    go(); go(); reset = 1'b1;
    @(negedge clk);
    check("t6 addr step2", 64'(bus.ucode_addr), 64'h32);
    go(); reset = 1'b0;
    @(negedge clk);
    check("t6 valid", 64'(bus.ctrl_valid),  64'd0);
    check("t6 done",  64'(bus.done),        64'd0);
    check("t6 out",   64'(bus.reg_out_en),  64'd0);
    check("t6 ready", 64'(bus.instr_ready), 64'd1);
    go(); bus.instr_valid = 1'b1;
    go(); bus.instr_valid = 1'b0;
    @(negedge clk);
    check("t6 restart addr", 64'(bus.ucode_addr), 64'h30);
    nd = 0; nv = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) nd++;
      if (bus.ctrl_valid) nv++;
    end
    check("t6 rerun words", 64'(nv), 64'd5);
    check("t6 rerun done",  64'(nd), 64'd1);

    // 5: NREG=3, out-of-range register indices
    rom3_word = {16'h1234, 3'b011};
    go(); bus3.instr_valid = 1'b1; bus3.opcode = 4'd2; bus3.rs = 2'd0; bus3.rd = 2'd3;
    go(); bus3.instr_valid = 1'b0;
    @(negedge clk);
    check("t5 busy", 64'(bus3.instr_ready), 64'd0);
    @(negedge clk);
    check("t5 in_en", 64'(bus3.reg_in_en),  64'b000);
    check("t5 err",   64'(bus3.decode_err), 64'd1);
    check("t5 valid", 64'(bus3.ctrl_valid), 64'd1);
    check("t5 ctrl",  64'(bus3.ctrl_out),   64'h1234);
    check("t5 done",  64'(bus3.done),       64'd1);
    @(negedge clk);
    check("t5 err gone", 64'(bus3.decode_err), 64'd0);
    rom3_word = {16'h4321, 3'b101};
    go(); bus3.instr_valid = 1'b1; bus3.rs = 2'd3; bus3.rd = 2'd2;
    go(); bus3.instr_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t5 out_en", 64'(bus3.reg_out_en), 64'b000);
    check("t5 err rs", 64'(bus3.decode_err), 64'd1);
    rom3_word = {16'h0F0F, 3'b011};
    go(); bus3.instr_valid = 1'b1;
    go(); bus3.instr_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t5 in_en top", 64'(bus3.reg_in_en),  64'b100);
    check("t5 no err",    64'(bus3.decode_err), 64'd0);

    // Randomized traffic against the model
    for (int a = 0; a < (1 << AW); a++)
      rom[AW'(a)] = {16'($urandom), 2'($urandom), ($urandom_range(0, 2) == 0)};
    for (int c = 0; c < 4000; c++) begin
      go();
      reset           = ($urandom_range(0, 299) == 0);
      bus.instr_valid = 1'($urandom);
      bus.opcode      = 4'($urandom);
      bus.rs          = 2'($urandom);
      bus.rd          = 2'($urandom);
      bus.stall       = ($urandom_range(0, 3) == 0);
    end
    go();
    reset = 1'b0; bus.instr_valid = 1'b0; bus.stall = 1'b0;
    repeat (12) go();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
